// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key_event press classifier.
package key_event_pkg;

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    IDLE      = 3'd1,
    PRESSED   = 3'd2,
    LONG_HELD = 3'd3
  } key_state_t;

  localparam int DEF_LONG_CYCLES   = 1000;
  localparam int DEF_REPEAT_CYCLES = 250;

endpackage : key_event_pkg

// File: rtl/key_event_hold_timer.sv
// Hold timer for key_event: counts high samples of the key and flags when the count
// reaches a limit that the owner can switch between the long-press and repeat phases.
module hold_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load1,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;

  // Clear wins over load so a phase change can never leave a stale count behind.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load1) begin
      count <= ONE;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

  assign tc = (count == limit);

endmodule : hold_timer

// File: rtl/key_event.sv
// Turns a debounced key level into short/long press pulses and a wrapping press count.
// Define AUTO_REPEAT_EN to add auto-repeat pulses while a long press is held.
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       key_held,
  output logic [7:0] press_count
);

  localparam logic [2:0] ST_ARM       = ARM;
  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_PRESSED   = PRESSED;
  localparam logic [2:0] ST_LONG_HELD = LONG_HELD;

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      (2 ** CNT_W) <= LONG_CYCLES || (2 ** CNT_W) <= REPEAT_CYCLES) begin : g_bad_params
    $error("key_event: invalid LONG_CYCLES/REPEAT_CYCLES/CNT_W combination");
  end

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic             t_clear;
  logic             t_load;
  logic             t_inc;
  logic             tc;
  logic [CNT_W-1:0] limit;
  logic             short_nxt;
  logic             long_nxt;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_CYCLES - 1);
  logic rep_nxt;

  // The single timer serves both phases, so its compare limit follows the state.
  assign limit = (state == ST_LONG_HELD) ? REP_LIM : LONG_LIM;
`else
  assign limit = LONG_LIM;
`endif

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(t_clear),
    .load1(t_load),
    .inc  (t_inc),
    .limit(limit),
    .tc   (tc)
  );

  always_comb begin
    next_state = state;
    t_clear    = 1'b0;
    t_load     = 1'b0;
    t_inc      = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_nxt    = 1'b0;
`endif
    case (state)
      // ARM swallows a key that was already down when reset released.
      ST_ARM: begin
        if (!key_in) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (key_in) begin
          next_state = ST_PRESSED;
          t_load     = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!key_in) begin
          next_state = ST_IDLE;
          short_nxt  = 1'b1;
        end else if (tc) begin
          next_state = ST_LONG_HELD;
          t_clear    = 1'b1;
          long_nxt   = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!key_in) begin
          next_state = ST_IDLE;
`ifdef AUTO_REPEAT_EN
        end else if (tc) begin
          rep_nxt = 1'b1;
          t_clear = 1'b1;
        end else begin
          t_inc = 1'b1;
`endif
        end
      end
      default: next_state = ST_ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ARM;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      key_held    <= 1'b0;
      press_count <= 8'h00;
    end else begin
      state       <= next_state;
      short_press <= short_nxt;
      long_press  <= long_nxt;
      key_held    <= (next_state == ST_PRESSED) || (next_state == ST_LONG_HELD);
      if (short_nxt || long_nxt) press_count <= press_count + 8'd1;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= rep_nxt;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule : key_event
